// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receive path.
//   uart_state_t              : receiver FSM state encoding
//   DATA_BITS                 : payload bits per frame
//   BIT_CNT_W                 : width of the data bit index
//   CLKS_PER_BIT_9600_100MHZ  : default clocks per bit (100 MHz / 9600 baud)
//   even_parity()             : XOR reduction used for 8E1 frames
// -----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        PARITY    = 3'd3,
        STOP      = 3'd4,
        WAIT_HIGH = 3'd5
    } uart_state_t;

    localparam int DATA_BITS                = 8;
    localparam int BIT_CNT_W                = $clog2(DATA_BITS);
    localparam int CLKS_PER_BIT_9600_100MHZ = 10416;

    // Expected parity bit for even parity: XOR of all data bits.
    function automatic logic even_parity(input logic [DATA_BITS-1:0] data);
        return ^data;
    endfunction

endpackage : uart_pkg

// File: rtl/sync_ff.sv
// -----------------------------------------------------------------------------
// sync_ff
// Multi-flop synchronizer for a single asynchronous input. Flops reset to 1 so
// an idle-high line (UART RX, pulled-up button) reads inactive out of reset.
// Parameters:
//   SYNC_STAGES : number of flops in the chain (>= 2)
// Ports:
//   clk   in  1  destination clock, rising edge
//   rst_n in  1  asynchronous active-low reset
//   i_d   in  1  asynchronous input
//   o_q   out 1  synchronized output
// -----------------------------------------------------------------------------
module sync_ff #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    logic [SYNC_STAGES-1:0] r_sync;

    // Shift chain: the input enters at bit 0 and leaves from the top bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= {SYNC_STAGES{1'b1}};
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
        end
    end

    assign o_q = r_sync[SYNC_STAGES-1];

endmodule : sync_ff

// File: rtl/uart_rx_byte.sv
// -----------------------------------------------------------------------------
// uart_rx_byte
// 8N1 asynchronous serial receiver, LSB first. The raw RX pin is synchronized,
// each bit is sampled at its middle, and a good frame updates a held byte and
// pulses rx_valid for one cycle. A low stop bit pulses frame_err and the
// receiver then waits for the line to return high before re-arming.
//
// Optional build macro: UART_RX_PARITY_EN
//   defined   -> 8E1 frames; a parity bit follows the data and a mismatch
//                (with a good stop bit) pulses parity_err instead of rx_valid
//   undefined -> 8N1 frames; parity_err is constant 0
//
// Parameters:
//   CLKS_PER_BIT : system clocks per bit (>= 4)
//   SYNC_STAGES  : flops in the RX synchronizer (>= 2)
// Ports:
//   clk        in  1  system clock, rising edge
//   rst_n      in  1  asynchronous active-low reset
//   rx         in  1  raw serial line, idle high
//   rx_data    out 8  last correctly received byte, held
//   rx_valid   out 1  one-cycle pulse when rx_data updates
//   frame_err  out 1  one-cycle pulse when the stop bit is low
//   parity_err out 1  one-cycle pulse on parity mismatch
//   busy       out 1  high whenever the FSM is not IDLE
// -----------------------------------------------------------------------------
module uart_rx_byte
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_9600_100MHZ,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 busy
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);

    localparam logic [BAUD_W-1:0]    BAUD_ZERO = BAUD_W'(0);
    localparam logic [BAUD_W-1:0]    BAUD_ONE  = BAUD_W'(1);
    localparam logic [BAUD_W-1:0]    BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    // Middle of the start bit; later samples land one full bit apart from it.
    localparam logic [BAUD_W-1:0]    HALF_LAST = BAUD_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BIT_CNT_W-1:0] BIT_ZERO  = BIT_CNT_W'(0);
    localparam logic [BIT_CNT_W-1:0] BIT_ONE   = BIT_CNT_W'(1);
    localparam logic [BIT_CNT_W-1:0] BIT_LAST  = BIT_CNT_W'(DATA_BITS - 1);

    logic                 w_rxs;
    uart_state_t          r_state;
    logic [BAUD_W-1:0]    r_baud_cnt;
    logic [BIT_CNT_W-1:0] r_bit_cnt;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] r_rx_data;
    logic                 r_rx_valid;
    logic                 r_frame_err;
    logic                 r_busy;
`ifdef UART_RX_PARITY_EN
    logic                 r_par_bit;
    logic                 r_parity_err;
`endif

    sync_ff #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_rx_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (rx),
        .o_q   (w_rxs)
    );

    // Receiver FSM with baud/bit counters, shift register and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_baud_cnt  <= BAUD_ZERO;
            r_bit_cnt   <= BIT_ZERO;
            r_shift     <= 8'h00;
            r_rx_data   <= 8'h00;
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
            r_busy      <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par_bit    <= 1'b0;
            r_parity_err <= 1'b0;
`endif
        end else begin
            // Strobes are single-cycle unless a branch below raises them.
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_parity_err <= 1'b0;
`endif
            case (r_state)
                IDLE: begin
                    r_baud_cnt <= BAUD_ZERO;
                    if (!w_rxs) begin
                        r_state <= START;
                        r_busy  <= 1'b1;
                    end else begin
                        r_busy  <= 1'b0;
                    end
                end

                START: begin
                    if (r_baud_cnt == HALF_LAST) begin
                        r_baud_cnt <= BAUD_ZERO;
                        if (!w_rxs) begin
                            r_bit_cnt <= BIT_ZERO;
                            r_state   <= DATA;
                        end else begin
                            // Line went back high before mid-bit: a glitch.
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + BAUD_ONE;
                    end
                end

                DATA: begin
                    if (r_baud_cnt == BAUD_LAST) begin
                        r_baud_cnt         <= BAUD_ZERO;
                        r_shift[r_bit_cnt] <= w_rxs;
                        if (r_bit_cnt == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                            r_state <= PARITY;
`else
                            r_state <= STOP;
`endif
                        end else begin
                            r_bit_cnt <= r_bit_cnt + BIT_ONE;
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + BAUD_ONE;
                    end
                end

`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (r_baud_cnt == BAUD_LAST) begin
                        r_baud_cnt <= BAUD_ZERO;
                        r_par_bit  <= w_rxs;
                        r_state    <= STOP;
                    end else begin
                        r_baud_cnt <= r_baud_cnt + BAUD_ONE;
                    end
                end
`endif

                STOP: begin
                    if (r_baud_cnt == BAUD_LAST) begin
                        r_baud_cnt <= BAUD_ZERO;
                        if (w_rxs) begin
                            // Re-arm mid stop bit so a back-to-back start edge
                            // half a bit later is still caught.
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
`ifdef UART_RX_PARITY_EN
                            if (r_par_bit != even_parity(r_shift)) begin
                                r_parity_err <= 1'b1;
                            end else begin
                                r_rx_data  <= r_shift;
                                r_rx_valid <= 1'b1;
                            end
`else
                            r_rx_data  <= r_shift;
                            r_rx_valid <= 1'b1;
`endif
                        end else begin
                            // Framing error outranks any parity result.
                            r_frame_err <= 1'b1;
                            r_state     <= WAIT_HIGH;
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + BAUD_ONE;
                    end
                end

                WAIT_HIGH: begin
                    // Hold off until the line idles so a break cannot look
                    // like a fresh start bit.
                    r_baud_cnt <= BAUD_ZERO;
                    if (w_rxs) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_state <= WAIT_HIGH;
                    end
                end

                default: begin
                    r_state    <= IDLE;
                    r_baud_cnt <= BAUD_ZERO;
                    r_busy     <= 1'b0;
                end
            endcase
        end
    end

    assign rx_data   = r_rx_data;
    assign rx_valid  = r_rx_valid;
    assign frame_err = r_frame_err;
    assign busy      = r_busy;
`ifdef UART_RX_PARITY_EN
    assign parity_err = r_parity_err;
`else
    assign parity_err = 1'b0;
`endif

endmodule : uart_rx_byte

// File: tb/tb_uart_rx_byte.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_byte
// Directed bench for uart_rx_byte with CLKS_PER_BIT=16. Frames are driven bit
// by bit on the falling clock edge; a monitor on the falling edge records every
// strobe so each scenario can compare pulse counts and captured bytes.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_rx_byte;

    localparam int CPB = 16;

    logic       clk;
    logic       rst_n;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       parity_err;
    logic       busy;

    int n_checks = 0;
    int n_pass   = 0;

    int         n_valid   = 0;
    int         n_ferr    = 0;
    int         n_perr    = 0;
    int         n_overlap = 0;
    logic [7:0] got_q[$];

`ifdef UART_RX_PARITY_EN
    logic par_flip = 1'b0;
`endif

    uart_rx_byte #(
        .CLKS_PER_BIT (CPB),
        .SYNC_STAGES  (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (rx),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record strobes and captured bytes away from the active edge.
    always @(negedge clk) begin
        if (rx_valid) begin
            n_valid = n_valid + 1;
            got_q.push_back(rx_data);
        end
        if (frame_err)  n_ferr = n_ferr + 1;
        if (parity_err) n_perr = n_perr + 1;
        if ((32'(rx_valid) + 32'(frame_err) + 32'(parity_err)) > 32'd1)
            n_overlap = n_overlap + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got === exp) begin
            n_pass = n_pass + 1;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] data, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(data[i]);
`ifdef UART_RX_PARITY_EN
        send_bit((^data) ^ par_flip);
`endif
        send_bit(stop);
    endtask

    initial begin
        int v0;
        int f0;
        rst_n = 1'b0;
        rx    = 1'b1;

        // Reset state
        idle_cycles(5);
        check("rst_data",   32'(rx_data),    32'h00);
        check("rst_valid",  32'(rx_valid),   32'h0);
        check("rst_ferr",   32'(frame_err),  32'h0);
        check("rst_perr",   32'(parity_err), 32'h0);
        check("rst_busy",   32'(busy),       32'h0);
        rst_n = 1'b1;
        idle_cycles(50);
        check("idle_no_pulse", 32'(n_valid + n_ferr + n_perr), 32'd0);
        check("idle_busy",     32'(busy), 32'h0);

        // Good frame 0xA5 then long idle
        send_frame(8'hA5, 1'b1);
        idle_cycles(4);
        check("a5_count", 32'(n_valid), 32'd1);
        check("a5_data",  32'(rx_data), 32'hA5);
        idle_cycles(1000);
        check("a5_hold",  32'(rx_data), 32'hA5);
        check("a5_count_hold", 32'(n_valid), 32'd1);

        // Glitch: 5 cycles low
        rx = 1'b0;
        idle_cycles(5);
        check("glitch_busy_hi", 32'(busy), 32'h1);
        rx = 1'b1;
        idle_cycles(30);
        check("glitch_busy_lo", 32'(busy), 32'h0);
        check("glitch_no_valid", 32'(n_valid), 32'd1);
        check("glitch_data", 32'(rx_data), 32'hA5);

        // Framing error: 0x3C with low stop bit, line low 40 more cycles
        send_frame(8'h3C, 1'b0);
        idle_cycles(40);
        check("ferr_count", 32'(n_ferr), 32'd1);
        check("ferr_no_valid", 32'(n_valid), 32'd1);
        check("ferr_data", 32'(rx_data), 32'hA5);
        check("ferr_busy_hold", 32'(busy), 32'h1);
        rx = 1'b1;
        idle_cycles(10);
        check("ferr_busy_release", 32'(busy), 32'h0);
        send_frame(8'h3C, 1'b1);
        idle_cycles(4);
        check("after_ferr_count", 32'(n_valid), 32'd2);
        check("after_ferr_data",  32'(rx_data), 32'h3C);

        // Back-to-back 0x00, 0xFF, 0x7E
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        send_frame(8'h7E, 1'b1);
        idle_cycles(20);
        check("b2b_count", 32'(n_valid), 32'd5);
        if (got_q.size() == 5) begin
            check("b2b_0", 32'(got_q[2]), 32'h00);
            check("b2b_1", 32'(got_q[3]), 32'hFF);
            check("b2b_2", 32'(got_q[4]), 32'h7E);
        end else begin
            check("b2b_qsize", 32'(got_q.size()), 32'd5);
        end
        check("b2b_ferr", 32'(n_ferr), 32'd1);

`ifdef UART_RX_PARITY_EN
        // Parity: correct then flipped
        v0 = n_valid;
        par_flip = 1'b0;
        send_frame(8'h01, 1'b1);
        idle_cycles(4);
        check("par_ok_valid", 32'(n_valid - v0), 32'd1);
        check("par_ok_data",  32'(rx_data), 32'h01);
        par_flip = 1'b1;
        send_frame(8'hA5, 1'b1);   // wrong parity; data must not land
        idle_cycles(4);
        check("par_bad_perr",  32'(n_perr), 32'd1);
        check("par_bad_valid", 32'(n_valid - v0), 32'd1);
        check("par_bad_data",  32'(rx_data), 32'h01);
        par_flip = 1'b0;
`endif

        // Mid-frame reset then a fresh good frame
        v0 = n_valid;
        f0 = n_ferr;
        rx = 1'b0;
        idle_cycles(80);
        rst_n = 1'b0;
        idle_cycles(1);
        check("midrst_data", 32'(rx_data), 32'h00);
        check("midrst_busy", 32'(busy), 32'h0);
        rst_n = 1'b1;
        rx    = 1'b1;
        idle_cycles(40);
        check("midrst_no_pulse", 32'(n_valid - v0 + n_ferr - f0), 32'd0);
        send_frame(8'h5A, 1'b1);
        idle_cycles(4);
        check("midrst_next_valid", 32'(n_valid - v0), 32'd1);
        check("midrst_next_data",  32'(rx_data), 32'h5A);

        check("strobe_exclusive", 32'(n_overlap), 32'd0);
`ifndef UART_RX_PARITY_EN
        check("perr_tied_low", 32'(n_perr), 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_uart_rx_byte

// File: doc/uart_rx_byte.md
Name: uart_rx_byte

Overview:
- Asynchronous serial receiver, 8N1 frame format, LSB first.
- Samples the raw RX pin and produces a held byte plus a one-cycle valid strobe.
- The held byte drives the two-digit hex 7-segment display stage directly downstream, on its 8-bit binary input.
- Sits between the board RX pin and the display/consumer logic, in the single system clock domain.

Parameters:
- CLKS_PER_BIT, 10416, system clock cycles per bit; 100 MHz / 9600 baud. Minimum legal value is 4.
- SYNC_STAGES, 2, flip-flops in the RX input synchronizer. Minimum 2.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rx  in  1  raw serial line; idle high.
- rx_data  out  8  last correctly received byte; held until the next good frame.
- rx_valid  out  1  one-cycle pulse when rx_data updates.
- frame_err  out  1  one-cycle pulse when the stop bit is sampled low.
- parity_err  out  1  one-cycle pulse on a parity mismatch; constant 0 without the optional feature.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset: one clock, asynchronous and active-low (clk, rst_n).
  - Reset values: rx_data=8'h00, rx_valid=0, frame_err=0, parity_err=0, busy=0.
  - State=IDLE, bit counter=0, baud counter=0, synchronizer flops=1.
- Reset mid-frame aborts immediately. The partial byte is discarded and rx_data keeps 8'h00.
- rx passes through the SYNC_STAGES-flop synchronizer. All decisions use the synchronized value rxs.
- Baud counter counts 0..CLKS_PER_BIT-1. Its width is $clog2(CLKS_PER_BIT).
- FSM states and transitions:
  - IDLE: when rxs==0, clear the baud counter and go to START.
  - START: wait until baud counter == CLKS_PER_BIT/2-1 (integer division), which is mid start bit.
    - rxs==0: clear the baud counter, clear the bit counter, go to DATA.
    - rxs==1: glitch; return to IDLE with no output pulse.
  - DATA: at each baud counter == CLKS_PER_BIT-1, shift rxs into bit[bit counter] (LSB first).
    - After bit 7, go to STOP, or to PARITY if the feature is enabled.
  - STOP: at baud counter == CLKS_PER_BIT-1, sample rxs.
    - rxs==1: rx_data<=shift register, rx_valid=1 for one cycle, go to IDLE.
    - rxs==0: frame_err=1 for one cycle, rx_data unchanged, go to WAIT_HIGH.
  - WAIT_HIGH (break/garbage recovery): stay until rxs==1, then go to IDLE. This prevents a held-low line from re-triggering START.
- Latency: rx_valid rises about SYNC_STAGES + CLKS_PER_BIT/2 + 9·CLKS_PER_BIT cycles after the falling start edge at the pin.
- Back-to-back frames:
  - IDLE is re-entered mid stop bit, so a start edge arriving half a bit later is caught with no lost frame.
  - rx_valid for frame N never overlaps frame N+1's processing.
- rx_valid, frame_err and parity_err are mutually exclusive in any cycle.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined: the frame is 8E1. A PARITY state follows DATA and samples one bit at baud counter == CLKS_PER_BIT-1.
  - Expected bit = XOR of the 8 data bits.
  - Mismatch at STOP with a good stop bit: parity_err pulses instead of rx_valid, rx_data unchanged, go to IDLE.
  - Bad stop bit: frame_err takes priority.
- Undefined: no PARITY state; parity_err tied to 0.

Decomposition:
- Shared package uart_pkg holds:
  - the state enum (IDLE, START, DATA, PARITY, STOP, WAIT_HIGH);
  - DATA_BITS=8;
  - the default CLKS_PER_BIT_9600_100MHZ=10416 constant.
- Sub-module sync_ff (parameter SYNC_STAGES, reset value 1) for the RX synchronizer. It is reusable for button inputs.
- Baud counter and FSM stay in uart_rx_byte.

Test Plan:
All scenarios use CLKS_PER_BIT=16.
- Reset: hold rst_n=0 with rx=1 → all outputs 0, busy=0. Release rst_n → no pulses while rx stays 1.
- Good frame 0xA5 (start 0, bits 1,0,1,0,0,1,0,1, stop 1) → exactly one rx_valid pulse, rx_data=8'hA5. rx_data holds 8'hA5 while the line idles for 1000 cycles.
- Glitch rejection: rx low for 5 cycles, then high → busy pulses briefly, returns to IDLE, no rx_valid, rx_data unchanged.
- Framing error: 0x3C with stop bit 0, then the line stays low 40 cycles → one frame_err pulse, rx_data keeps its prior value, busy stays high until rx returns to 1. A following 0x3C with a good stop bit yields rx_valid and rx_data=8'h3C.
- Back-to-back: 0x00, 0xFF, 0x7E with zero idle gap → three rx_valid pulses in order, with rx_data 8'h00, 8'hFF, 8'h7E.
- With UART_RX_PARITY_EN: 0x01 with parity 1 → rx_valid. 0x01 with parity 0 → parity_err pulse, no rx_valid. A mid-frame rst_n pulse → rx_data=8'h00 and the next good frame is received normally.
